// File: rtl/aes128_cipher_iter.sv
// AES-128 encryption core: one round per clock over a valid/ready handshake.
// Ports: clk, rst_n (async low); in_valid/in_ready/plaintext/round_keys in;
//        out_valid/out_ready/ciphertext out; busy while a job is in flight.
module aes128_cipher_iter #(
   parameter int NR   = 10,
   parameter int KS_W = 128*(NR+1)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [127:0]    plaintext,
   input  logic [KS_W-1:0] round_keys,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [127:0]    ciphertext,
   output logic            busy
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ROUND,
      S_DONE
   } state_t;

   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] f_xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Byte i of the state sits at [127-8i -: 8]; byte 4c+r is row r, column c.
   function automatic logic [127:0] f_sub_bytes(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int i = 0; i < 16; i++)
         o[127-8*i -: 8] = SBOX[s[127-8*i -: 8]];
      return o;
   endfunction

   function automatic logic [127:0] f_shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      return o;
   endfunction

   function automatic logic [127:0] f_mix_columns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c    -: 8];
         a1 = s[127-32*c-8  -: 8];
         a2 = s[127-32*c-16 -: 8];
         a3 = s[127-32*c-24 -: 8];
         o[127-32*c    -: 8] = f_xtime(a0) ^ f_xtime(a1) ^ a1 ^ a2 ^ a3;
         o[127-32*c-8  -: 8] = a0 ^ f_xtime(a1) ^ f_xtime(a2) ^ a2 ^ a3;
         o[127-32*c-16 -: 8] = a0 ^ a1 ^ f_xtime(a2) ^ f_xtime(a3) ^ a3;
         o[127-32*c-24 -: 8] = f_xtime(a0) ^ a0 ^ a1 ^ a2 ^ f_xtime(a3);
      end
      return o;
   endfunction

   state_t       r_state, w_state_nxt;
   logic [3:0]   r_rnd, w_rnd_nxt;
   logic [127:0] r_st, w_st_nxt;

   logic [127:0] w_sr;
   logic [127:0] w_mc;
   logic [127:0] w_rk;
   logic [127:0] w_round;
   logic         w_last;

   assign w_sr    = f_shift_rows(f_sub_bytes(r_st));
   assign w_mc    = f_mix_columns(w_sr);
   assign w_rk    = round_keys[int'(r_rnd)*128 +: 128];
   assign w_last  = (r_rnd == 4'(NR));
   // The final round has no MixColumns.
   assign w_round = (w_last ? w_sr : w_mc) ^ w_rk;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_rnd   <= 4'd0;
         r_st    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_rnd   <= w_rnd_nxt;
         r_st    <= w_st_nxt;
      end
   end

   // Inputs are only looked at in the state that uses them, so X on
   // in_valid during ROUND or out_ready outside DONE cannot leak in.
   always_comb begin
      w_state_nxt = r_state;
      w_rnd_nxt   = r_rnd;
      w_st_nxt    = r_st;
      unique case (r_state)
         S_IDLE: begin
            if (in_valid) begin
               w_st_nxt    = plaintext ^ round_keys[127:0];
               w_rnd_nxt   = 4'd1;
               w_state_nxt = S_ROUND;
            end
         end
         S_ROUND: begin
            w_st_nxt = w_round;
            if (w_last) w_state_nxt = S_DONE;
            else        w_rnd_nxt   = r_rnd + 4'd1;
         end
         S_DONE: begin
            if (out_ready) begin
               w_state_nxt = S_IDLE;
               w_rnd_nxt   = 4'd0;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_rnd_nxt   = 4'd0;
         end
      endcase
   end

   assign in_ready   = (r_state == S_IDLE);
   assign out_valid  = (r_state == S_DONE);
   assign busy       = (r_state != S_IDLE);
   // Intermediate round states never appear on the output.
   assign ciphertext = out_valid ? r_st : '0;

endmodule
